// File: rtl/ceyloniac_loader_pkg.sv
// Shared types for the program loader: FSM encoding and byte-index width.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package ceyloniac_loader_pkg;

  localparam int BYTE_IDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_COLLECT = 3'd3,
    S_WRITE   = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd5,
`endif
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/ceyloniac_byte_packer.sv
// Little-endian 4-byte assembler; word_full flags the byte
// that completes the current word.
module ceyloniac_byte_packer
  import ceyloniac_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BYTE_IDX_W-1:0] idx;

  assign word_full = shift && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (shift) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/ceyloniac_program_loader.sv
// Byte-stream program loader driving the RAM controller external port.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module ceyloniac_program_loader
  import ceyloniac_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  ram_external_control_enable,
  output logic                  external_ram_enable,
  output logic                  external_ram_write_enable,
  output logic                  external_ram_read_enable,
  output logic [ADDR_WIDTH-1:0] external_ram_addr,
  output logic [DATA_WIDTH-1:0] external_ram_write_data,
  output logic                  loader_busy,
  output logic                  load_done,
  output logic                  load_error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHECK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t state, state_n;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [15:0]           cnt;
  logic [15:0]           cnt_inc;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           word;
  logic                  word_full;
  logic                  xfer;
  logic                  accept;

  assign xfer    = byte_valid && byte_ready;
  assign accept  = (state == S_IDLE) && load_start;
  assign cnt_inc = cnt + 16'd1;

  always_comb begin
    byte_ready = 1'b0;
    unique case (state)
      S_LEN_LO, S_LEN_HI, S_COLLECT: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: byte_ready = 1'b1;
`endif
      default: byte_ready = 1'b0;
    endcase
  end

  assign loader_busy                 = (state != S_IDLE);
  assign ram_external_control_enable = (state != S_IDLE);
  assign external_ram_enable         = (state != S_IDLE);
  assign external_ram_write_enable   = (state == S_WRITE);
  assign external_ram_read_enable    = 1'b0;
  assign load_done                   = (state == S_DONE);
  assign external_ram_addr           = addr;
  assign external_ram_write_data     = word;

  ceyloniac_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .shift     ((state == S_COLLECT) && xfer),
    .byte_in   (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (load_start) state_n = S_LEN_LO;
      S_LEN_LO:  if (xfer) state_n = S_LEN_HI;
      S_LEN_HI:
        if (xfer)
          state_n = ({byte_data, len_lo} == 16'd0) ? S_FIN : S_COLLECT;
      S_COLLECT: if (word_full) state_n = S_WRITE;
      S_WRITE:   state_n = (cnt_inc == len) ? S_FIN : S_COLLECT;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:   if (xfer) state_n = S_DONE;
`endif
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo <= '0;
      len    <= '0;
      cnt    <= '0;
      addr   <= '0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        addr <= BASE_ADDR;
      end
      if (state == S_LEN_LO && xfer) len_lo <= byte_data;
      if (state == S_LEN_HI && xfer) len <= {byte_data, len_lo};
      if (state == S_WRITE) begin
        cnt  <= cnt_inc;
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err;

  // Length bytes are excluded; only data bytes fold into the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (state == S_COLLECT && xfer) csum <= csum ^ byte_data;
      if (state == S_CHECK && xfer) err <= (byte_data != csum);
    end
  end

  assign load_error = err;
`else
  assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_ceyloniac_program_loader.sv
// Self-checking bench: table of loads with a write scoreboard,
// plus reset-mid-load and busy load_start sequences.
module tb_ceyloniac_program_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic sel = 1'b0;
  logic [7:0] data = 8'h00;

  always #5 clk = ~clk;

  logic a_rdy, a_ctrl, a_en, a_we, a_re, a_busy, a_done, a_err;
  logic b_rdy, b_ctrl, b_en, b_we, b_re, b_busy, b_done, b_err;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wd, b_wd;

  ceyloniac_program_loader #(.BASE_ADDR(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .load_start(start & ~sel), .byte_valid(valid & ~sel),
    .byte_data(data), .byte_ready(a_rdy),
    .ram_external_control_enable(a_ctrl),
    .external_ram_enable(a_en),
    .external_ram_write_enable(a_we),
    .external_ram_read_enable(a_re),
    .external_ram_addr(a_addr),
    .external_ram_write_data(a_wd),
    .loader_busy(a_busy), .load_done(a_done), .load_error(a_err)
  );

  ceyloniac_program_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .load_start(start & sel), .byte_valid(valid & sel),
    .byte_data(data), .byte_ready(b_rdy),
    .ram_external_control_enable(b_ctrl),
    .external_ram_enable(b_en),
    .external_ram_write_enable(b_we),
    .external_ram_read_enable(b_re),
    .external_ram_addr(b_addr),
    .external_ram_write_data(b_wd),
    .loader_busy(b_busy), .load_done(b_done), .load_error(b_err)
  );

  wire s_rdy  = sel ? b_rdy  : a_rdy;
  wire s_ctrl = sel ? b_ctrl : a_ctrl;
  wire s_en   = sel ? b_en   : a_en;
  wire s_we   = sel ? b_we   : a_we;
  wire s_re   = sel ? b_re   : a_re;
  wire s_busy = sel ? b_busy : a_busy;
  wire s_done = sel ? b_done : a_done;
  wire s_err  = sel ? b_err  : a_err;
  wire [15:0] s_addr = sel ? b_addr : a_addr;
  wire [31:0] s_wd   = sel ? b_wd   : a_wd;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit          sel;
    int          n;
    logic [31:0] w[4];
    bit          stall;
    bit          bad;
    logic [15:0] a0;
  } vec_t;

  wr_t  q[$];
  vec_t tbl[6];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   prev_we = 1'b0;
  bit   phase = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr, data}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_we) begin
        chk("spurious_write", q.size() == 0, 0);
        chk("strobe_width", prev_we, 0);
        chk("ctrl_during_write", {s_ctrl, s_en, s_re}, 3'b110);
        if (q.size() != 0) begin
          wr_t e;
          e = q.pop_front();
          chk("write_addr", s_addr, e.a);
          chk("write_data", s_wd, e.d);
        end
      end
      if (s_done) done_cnt++;
    end
    prev_we = s_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (stall && phase) begin
        valid = 1'b0;
        phase = ~phase;
      end else begin
        phase = ~phase;
        valid = 1'b1;
        data = b;
        if (s_rdy) ok = 1'b1;
      end
    end
    if (!ok) chk("byte_accept", ok, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0] cs;
    logic [15:0] n16;
    bit exp_err;
    int k, d0;
    cs = 8'h00;
    n16 = 16'(v.n);
    sel = v.sel;
    phase = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    exp_err = v.bad;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < v.n; i++)
      q.push_back('{v.a0 + 16'(i), v.w[i]});
    d0 = done_cnt;
    pulse_start();
    chk("busy_after_start", {s_busy, s_ctrl, s_en}, 3'b111);
    send_byte(n16[7:0], v.stall);
    send_byte(n16[15:8], v.stall);
    for (int i = 0; i < v.n; i++)
      for (int j = 0; j < 4; j++) begin
        cs ^= v.w[i][j*8 +: 8];
        send_byte(v.w[i][j*8 +: 8], v.stall);
      end
`ifdef LOADER_CHECKSUM_EN
    send_byte(v.bad ? (cs ^ 8'h01) : cs, v.stall);
`endif
    k = 0;
    do begin
      @(negedge clk);
      valid = 1'b0;
      k++;
    end while (!s_done && k < 30);
    chk("done_seen", s_done, 1);
    if (v.n == 0) chk("n0_done_latency", k <= 3, 1);
    chk("load_error", s_err, exp_err);
    @(negedge clk);
    chk("release", {s_ctrl, s_en, s_busy, s_done}, 4'b0000);
    chk("error_sticky", s_err, exp_err);
    chk("writes_drained", q.size(), 0);
    chk("done_once", done_cnt - d0, 1);
    q.delete();
  endtask

  function automatic vec_t mk(bit s, int n, logic [31:0] w0, logic [31:0] w1,
                              logic [31:0] w2, logic [31:0] w3,
                              bit st, bit bc, logic [15:0] a0);
    vec_t v;
    v.sel = s; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.stall = st; v.bad = bc; v.a0 = a0;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(0, 3, 32'h00000001, 32'hDEADBEEF, 32'h12345678, 0, 0, 0, 16'h0000);
    tbl[1] = mk(0, 3, 32'h00000001, 32'hDEADBEEF, 32'h12345678, 0, 1, 0, 16'h0000);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tbl[3] = mk(1, 2, 32'hCAFEF00D, 32'h80000001, 0, 0, 0, 0, 16'hFFFF);
    tbl[4] = mk(0, 1, 32'hA5A55A5A, 0, 0, 0, 0, 1, 16'h0000);
    tbl[5] = mk(0, 4, 32'hFFFFFFFF, 32'h00000000, 32'hA5A55A5A, 32'h01020304,
                1, 0, 16'h0000);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    valid = 1'b1;
    data = 8'h77;
    @(negedge clk);
    chk("reset_a", {a_rdy, a_ctrl, a_en, a_we, a_re, a_addr, a_wd,
                    a_busy, a_done, a_err}, 0);
    chk("reset_b", {b_rdy, b_ctrl, b_en, b_we, b_re, b_addr, b_wd,
                    b_busy, b_done, b_err}, 0);
    valid = 1'b0;

    for (int t = 0; t < 6; t++) run_load(tbl[t]);

    // Mid-load reset; a load_start while busy must be ignored first.
    begin
      vec_t v;
      int k, d0;
      v = mk(0, 4, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
             0, 0, 16'h0000);
      sel = 1'b0;
      phase = 1'b0;
      for (int i = 0; i < 4; i++) q.push_back('{16'(i), v.w[i]});
      d0 = done_cnt;
      pulse_start();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      for (int j = 0; j < 4; j++) send_byte(v.w[0][j*8 +: 8], 0);
      @(negedge clk);
      valid = 1'b0;
      start = 1'b1;
      for (int j = 0; j < 4; j++) send_byte(v.w[1][j*8 +: 8], 0);
      k = 0;
      do begin
        @(negedge clk);
        valid = 1'b0;
        k++;
      end while (q.size() > 2 && k < 10);
      chk("two_words_written", q.size(), 2);
      chk("busy_midload", {a_busy, a_ctrl}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", {a_rdy, a_ctrl, a_en, a_we, a_re, a_addr, a_wd,
                              a_busy, a_done, a_err}, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_done_after_reset", done_cnt - d0, 0);
      chk("idle_after_reset", {a_busy, a_ctrl}, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ceyloniac_program_loader.md
Name: ceyloniac_program_loader

Overview:
Upstream feeder for ceyloniac_ram_controller's external port. It accepts a byte stream carrying a program image and assembles the bytes into 32-bit words. It writes those words into RAM through the external_ram_* port, holding ram_external_control_enable high for the whole load. When the load completes it hands RAM back to the processor and pulses load_done.

Parameters:
ADDR_WIDTH, 16, RAM word-address width
DATA_WIDTH, 32, RAM word width (fixed at 4 bytes; other values unsupported)
BASE_ADDR, 16'h0000, word address of the first loaded word

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle request to begin a load; ignored unless in IDLE
byte_valid  in  1  byte_data is valid
byte_data  in  8  incoming stream byte
byte_ready  out  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
ram_external_control_enable  out  1  external port owns RAM
external_ram_enable  out  1  RAM enable
external_ram_write_enable  out  1  one-cycle write strobe
external_ram_read_enable  out  1  tied 0
external_ram_addr  out  ADDR_WIDTH  word address
external_ram_write_data  out  DATA_WIDTH  assembled word
loader_busy  out  1  high from load_start accept until DONE exits
load_done  out  1  one-cycle pulse at end of load
load_error  out  1  sticky until next load_start (checksum feature only; else 0)

Behaviour:
- Reset, asynchronous: all outputs 0, FSM to IDLE, counters and shift registers 0. This applies mid-load too. The partially written RAM is left as is and control returns to the processor immediately.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes with each word little-endian (first byte = bits 7:0).
- FSM states: IDLE, LEN_LO, LEN_HI, COLLECT, WRITE, [CHECK], DONE.
- IDLE -> LEN_LO on load_start. In that same edge: loader_busy=1, ram_external_control_enable=1, external_ram_enable=1.
- LEN_LO -> LEN_HI on transfer. LEN_HI -> COLLECT on transfer, or -> DONE (CHECK if the feature is enabled) if N==0.
- COLLECT: byte_ready=1. On each transfer, shift the byte into the word register at byte index 0..3. The transfer of byte 3 moves to WRITE.
- WRITE: exactly one cycle. byte_ready=0, external_ram_write_enable=1, and addr/data stable. The first addr is BASE_ADDR and each later write adds +1, wrapping modulo 2^ADDR_WIDTH. Word counter increments. -> COLLECT if words_written<N, else DONE/CHECK.
- Throughput: 1 word per 5 cycles at best. byte_valid stalls are allowed at any point and cause no state change.
- DONE: one cycle. load_done=1, ram_external_control_enable=0, external_ram_enable=0, loader_busy=0 at the exit edge. -> IDLE.
- byte_ready=1 only in LEN_LO, LEN_HI, COLLECT (and CHECK). It is 0 in IDLE, WRITE and DONE. Bytes presented in IDLE are not consumed.
- load_start while busy is ignored.
- N=16'hFFFF is legal. Address wraps silently past the top of RAM.

Optional Feature:
LOADER_CHECKSUM_EN.
- With the macro: after the last word, the CHECK state accepts one extra byte. That byte must equal the XOR of all data bytes; the length bytes are excluded. A mismatch sets load_error=1 in the same edge that enters DONE.
- Without the macro: there is no CHECK state, LEN/data go directly to DONE, and load_error is constant 0.

Decomposition:
- Shared package ceyloniac_loader_pkg holds the FSM state encoding constants and the byte-index width.
- One natural sub-module is ceyloniac_byte_packer: a 4-byte little-endian shift/assemble register with a word_full flag. The top module holds the FSM, counters and RAM-port drive.

Test Plan:
1. rst_n low then high, no stimulus -> every output 0; byte_ready=0 while byte_valid=1 in IDLE.
2. load_start, stream 03 00 then 12 bytes for words 0x00000001, 0xDEADBEEF, 0x12345678 -> three single-cycle write strobes at addr 0,1,2 with those data values. ram_external_control_enable is high throughout. load_done pulses once, then control drops to 0.
3. Same load with byte_valid toggled 1/0 every cycle -> identical RAM writes; no write occurs for a partial word.
4. Stream 00 00 -> no write strobe; load_done pulses within 3 cycles of LEN_HI.
5. BASE_ADDR=16'hFFFF, N=2 -> writes land at addr FFFF then 0000.
6. rst_n pulsed low after the 2nd word of an N=4 load -> outputs 0 asynchronously and load_done never pulses. With LOADER_CHECKSUM_EN, a load with a wrong checksum byte gives load_error=1 alongside load_done; a correct byte gives load_error=0.
